// File: rtl/uart_rx_frame_ctrl_if.sv
// rtl/uart_rx_frame_ctrl_if.sv - byte input, payload stream and status signals of the frame controller
interface uart_rx_frame_ctrl_if #(
    parameter int data_width = 8
);
    logic [data_width-1:0] rx_data;
    logic                  rx_data_ready;
    logic                  out_ready;
    logic [data_width-1:0] out_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  frame_ok;
    logic                  frame_err;
    logic [1:0]            err_code;
    logic                  busy;

    // Driver side: the UART receiver plus the downstream consumer.
    modport master (
        output rx_data, rx_data_ready, out_ready,
        input  out_data, out_valid, out_last, frame_ok, frame_err, err_code, busy
    );

    // Frame controller side.
    modport slave (
        input  rx_data, rx_data_ready, out_ready,
        output out_data, out_valid, out_last, frame_ok, frame_err, err_code, busy
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - validates SOF/len/payload/checksum frames and releases the payload as a stream
module uart_rx_frame_ctrl #(
    parameter int                  data_width     = 8,
    parameter logic [data_width-1:0] sof_byte     = 8'hA5,
    parameter int                  max_len        = 16,
    parameter int                  timeout_cycles = 1024
) (
    input  logic                clock_i,
    input  logic                reset_ni,
    uart_rx_frame_ctrl_if.slave bus
);
    localparam int idx_w = (max_len > 1) ? $clog2(max_len) : 1;
    localparam int cnt_w = $clog2(timeout_cycles + 1);
    localparam logic [data_width-1:0] max_len_b = data_width'(max_len);
    localparam logic [cnt_w-1:0]      idle_last = cnt_w'(timeout_cycles - 1);

    typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHECK, DRAIN} state_t;

    state_t                state_q, state_d;
    logic                  rdy_q;
    logic                  byte_ev;
    logic [data_width-1:0] len_q, len_d;
    logic [data_width-1:0] sum_q, sum_d;
    logic [idx_w-1:0]      wr_idx_q, wr_idx_d;
    logic [idx_w-1:0]      rd_idx_q, rd_idx_d;
    logic [cnt_w-1:0]      idle_q, idle_d;
    logic                  ok_q, ok_d;
    logic                  err_q, err_d;
    logic [1:0]            code_q, code_d;
    logic                  wr_en;
    logic [data_width-1:0] len_m1;
    logic                  wr_at_end;
    logic                  rd_at_end;
    logic                  timed;
    logic                  draining;
    logic [data_width-1:0] frame_buf_q [max_len];

    // rdy_q starts high so a flag already asserted out of reset never counts as a new byte.
    assign byte_ev   = bus.rx_data_ready & ~rdy_q;
    assign len_m1    = len_q - 1'b1;
    assign wr_at_end = (data_width'(wr_idx_q) == len_m1);
    assign rd_at_end = (data_width'(rd_idx_q) == len_m1);
    assign timed     = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHECK);
    assign draining  = (state_q == DRAIN);

    // Everything visible is derived from reset-cleared state, so outputs drop as soon as reset asserts.
    assign bus.out_valid = draining;
    assign bus.out_data  = draining ? frame_buf_q[rd_idx_q] : '0;
    assign bus.out_last  = draining && rd_at_end;
    assign bus.frame_ok  = ok_q;
    assign bus.frame_err = err_q;
    assign bus.err_code  = err_q ? code_q : 2'd0;
    assign bus.busy      = (state_q != HUNT);

    // Next-state, datapath updates and status pulses.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        sum_d    = sum_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        idle_d   = idle_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        code_d   = 2'd0;
        wr_en    = 1'b0;

        case (state_q)
            HUNT: begin
                if (byte_ev && bus.rx_data == sof_byte) begin
                    state_d = LEN;
                    idle_d  = '0;
                end
            end
            LEN: begin
                if (byte_ev) begin
                    if (bus.rx_data == '0 || bus.rx_data > max_len_b) begin
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                        state_d = HUNT;
                    end else begin
                        len_d    = bus.rx_data;
                        sum_d    = bus.rx_data;
                        wr_idx_d = '0;
                        state_d  = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (byte_ev) begin
                    wr_en = 1'b1;
                    sum_d = sum_q + bus.rx_data;
                    if (wr_at_end) begin
                        state_d = CHECK;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                if (byte_ev) begin
                    if (bus.rx_data == sum_q) begin
                        ok_d     = 1'b1;
                        rd_idx_d = '0;
                        state_d  = DRAIN;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = 2'd2;
                        state_d = HUNT;
                    end
                end
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    if (rd_at_end) begin
                        state_d = HUNT;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
                // The buffer holds one frame only, so a byte arriving now is lost.
                if (byte_ev) begin
                    err_d  = 1'b1;
                    code_d = 2'd0;
                end
            end
            default: state_d = HUNT;
        endcase

        // Inter-byte watchdog; a byte landing on the expiry cycle wins.
        if (timed) begin
            if (byte_ev) begin
                idle_d = '0;
            end else if (idle_q == idle_last) begin
                err_d   = 1'b1;
                code_d  = 2'd3;
                state_d = HUNT;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    // Control and status registers.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= HUNT;
            rdy_q    <= 1'b1;
            len_q    <= '0;
            sum_q    <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            idle_q   <= '0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= bus.rx_data_ready;
            len_q    <= len_d;
            sum_q    <= sum_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            idle_q   <= idle_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    // Payload buffer; contents are don't-care until written by the current frame.
    always_ff @(posedge clock_i) begin
        if (wr_en) begin
            frame_buf_q[wr_idx_q] <= bus.rx_data;
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - table-driven and directed checks for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_frame_ctrl_if bus ();

    uart_rx_frame_ctrl dut (
        .clock_i  (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_ev  = 0;

    int         ok_cnt    = 0;
    int         err_cnt   = 0;
    int         both_cnt  = 0;
    int         beat_cnt  = 0;
    int         last_code = 0;
    int         err_cyc   = 0;
    logic [7:0] beat_d [0:1023];
    logic       beat_l [0:1023];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.frame_ok) ok_cnt <= ok_cnt + 1;
        if (bus.frame_err) begin
            err_cnt   <= err_cnt + 1;
            last_code <= int'(bus.err_code);
            err_cyc   <= cyc;
        end
        if (bus.frame_ok && bus.frame_err) both_cnt <= both_cnt + 1;
        if (bus.out_valid && bus.out_ready) begin
            beat_d[beat_cnt % 1024] <= bus.out_data;
            beat_l[beat_cnt % 1024] <= bus.out_last;
            beat_cnt <= beat_cnt + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One receiver byte: flag high for two clocks, then low long enough to re-arm the edge detector.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #2;
        bus.rx_data       = b;
        bus.rx_data_ready = 1'b1;
        @(posedge clk);
        #1;
        last_ev = cyc;
        @(posedge clk);
        #2;
        bus.rx_data_ready = 1'b0;
        @(posedge clk);
        #2;
    endtask

    typedef struct {
        int start;
        int n;
        int ok;
        int err;
        int code;
        int es;
        int nb;
    } vec_t;

    vec_t       vecs [9];
    logic [7:0] stim_q [$];
    logic [7:0] exp_q [$];

    int ok0, err0, b0, ev0, hold_bad;

    initial begin
        stim_q = {8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09,
                  8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h0A,
                  8'hA5, 8'h01, 8'h7F, 8'h80,
                  8'h00, 8'hFF, 8'h11,
                  8'hA5, 8'h00,
                  8'hA5, 8'h11,
                  8'hA5, 8'h02, 8'hFF, 8'h02, 8'h03,
                  8'hA5, 8'hA5,
                  8'hA5, 8'h10};
        for (int i = 0; i < 16; i++) stim_q.push_back(8'(i));
        stim_q.push_back(8'h88);
        exp_q = {8'h01, 8'h02, 8'h03, 8'h7F, 8'hFF, 8'h02};
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));

        //          start  n  ok err code es nb
        vecs[0] = '{0,    6, 1, 0, 0, 0, 3};
        vecs[1] = '{6,    6, 0, 1, 2, 0, 0};
        vecs[2] = '{12,   4, 1, 0, 0, 3, 1};
        vecs[3] = '{16,   3, 0, 0, 0, 0, 0};
        vecs[4] = '{19,   2, 0, 1, 1, 0, 0};
        vecs[5] = '{21,   2, 0, 1, 1, 0, 0};
        vecs[6] = '{23,   5, 1, 0, 0, 4, 2};
        vecs[7] = '{28,   2, 0, 1, 1, 0, 0};
        vecs[8] = '{30,  19, 1, 0, 0, 6, 16};

        bus.rx_data       = 8'h00;
        bus.rx_data_ready = 1'b0;
        bus.out_ready     = 1'b1;

        tick(3);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_out_valid", int'(bus.out_valid), 0);
        chk("reset_flags", int'({bus.frame_ok, bus.frame_err, bus.err_code, bus.out_last}), 0);
        rst_n = 1'b1;
        tick(2);
        chk("post_reset_busy", int'(bus.busy), 0);

        // Table-driven frames with the consumer always ready.
        for (int v = 0; v < 9; v++) begin
            ok0 = ok_cnt;
            err0 = err_cnt;
            b0 = beat_cnt;
            for (int i = 0; i < vecs[v].n; i++) send_byte(stim_q[vecs[v].start + i]);
            tick(24);
            chk($sformatf("v%0d_ok", v), ok_cnt - ok0, vecs[v].ok);
            chk($sformatf("v%0d_err", v), err_cnt - err0, vecs[v].err);
            if (vecs[v].err > 0) chk($sformatf("v%0d_code", v), last_code, vecs[v].code);
            chk($sformatf("v%0d_beats", v), beat_cnt - b0, vecs[v].nb);
            for (int k = 0; k < vecs[v].nb && k < beat_cnt - b0; k++) begin
                chk($sformatf("v%0d_data%0d", v, k), int'(beat_d[(b0 + k) % 1024]), int'(exp_q[vecs[v].es + k]));
                chk($sformatf("v%0d_last%0d", v, k), int'(beat_l[(b0 + k) % 1024]), (k == vecs[v].nb - 1) ? 1 : 0);
            end
            chk($sformatf("v%0d_busy", v), int'(bus.busy), 0);
        end

        // Timeout fires exactly timeout_cycles clocks after the last byte.
        err0 = err_cnt;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h55);
        ev0 = last_ev;
        while (cyc < ev0 + 1100 && err_cnt == err0) begin
            @(posedge clk);
            #1;
        end
        tick(1);
        chk("tmo_err", err_cnt - err0, 1);
        chk("tmo_code", last_code, 3);
        chk("tmo_delay", err_cyc - ev0, 1024);
        chk("tmo_busy", int'(bus.busy), 0);

        // A byte on the expiry cycle suppresses the timeout.
        err0 = err_cnt;
        ok0 = ok_cnt;
        b0 = beat_cnt;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h55);
        ev0 = last_ev;
        while (cyc < ev0 + 1022) begin
            @(posedge clk);
            #1;
        end
        send_byte(8'h66);
        tick(2);
        chk("sup_ev_cycle", last_ev - ev0, 1024);
        chk("sup_no_err", err_cnt - err0, 0);
        send_byte(8'hBD);
        tick(6);
        chk("sup_ok", ok_cnt - ok0, 1);
        chk("sup_beats", beat_cnt - b0, 2);
        chk("sup_data0", int'(beat_d[b0 % 1024]), 8'h55);
        chk("sup_data1", int'(beat_d[(b0 + 1) % 1024]), 8'h66);

        // Backpressure with an overrun byte during the stall.
        bus.out_ready = 1'b0;
        err0 = err_cnt;
        ok0 = ok_cnt;
        b0 = beat_cnt;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'h67);
        chk("bp_ok", ok_cnt - ok0, 1);
        hold_bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!(bus.out_valid && bus.out_data == 8'hAA && !bus.out_last)) hold_bad++;
            if (i == 50) begin
                bus.rx_data       = 8'h33;
                bus.rx_data_ready = 1'b1;
            end
            if (i == 53) bus.rx_data_ready = 1'b0;
        end
        chk("bp_hold", hold_bad, 0);
        chk("bp_err", err_cnt - err0, 1);
        chk("bp_code", last_code, 0);
        chk("bp_no_beats", beat_cnt - b0, 0);
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        tick(5);
        chk("bp_beats", beat_cnt - b0, 2);
        chk("bp_data0", int'(beat_d[b0 % 1024]), 8'hAA);
        chk("bp_last0", int'(beat_l[b0 % 1024]), 0);
        chk("bp_data1", int'(beat_d[(b0 + 1) % 1024]), 8'hBB);
        chk("bp_last1", int'(beat_l[(b0 + 1) % 1024]), 1);
        chk("bp_busy", int'(bus.busy), 0);

        // Reset while draining, then release with the byte flag held high.
        bus.out_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h7F);
        send_byte(8'h80);
        tick(2);
        chk("rst_pre_valid", int'(bus.out_valid), 1);
        bus.rx_data       = 8'hA5;
        bus.rx_data_ready = 1'b1;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", int'(bus.out_valid), 0);
        chk("rst_async_busy", int'(bus.busy), 0);
        chk("rst_async_data", int'(bus.out_data), 0);
        chk("rst_async_flags", int'({bus.frame_ok, bus.frame_err, bus.err_code, bus.out_last}), 0);
        tick(3);
        rst_n = 1'b1;
        ok0 = ok_cnt;
        err0 = err_cnt;
        b0 = beat_cnt;
        tick(5);
        chk("held_flag_busy", int'(bus.busy), 0);
        bus.rx_data_ready = 1'b0;
        bus.out_ready     = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h7F);
        send_byte(8'h80);
        tick(5);
        chk("after_rst_ok", ok_cnt - ok0, 1);
        chk("after_rst_err", err_cnt - err0, 0);
        chk("after_rst_beats", beat_cnt - b0, 1);
        chk("after_rst_data", int'(beat_d[b0 % 1024]), 8'h7F);
        chk("ok_err_exclusive", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Frame controller that sits directly behind the UART receiver. It turns the receiver's byte stream into validated packets. Each frame is a start byte, a length, a payload and a checksum. The payload is buffered internally and released on a valid/ready stream only after the checksum passes. Bad frames are discarded and reported with an error code.

## Interface
- `data_width`, 8: byte width; fixed at 8 for this block.
- `sof_byte`, 8'hA5: start-of-frame marker.
- `max_len`, 16: maximum payload length (1..255); also the frame buffer depth.
- `timeout_cycles`, 1024: idle clocks allowed between bytes inside a frame.

- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  byte from the UART receiver; stable while `rx_data_ready` is high.
- `rx_data_ready`  in  1  receiver byte flag; level, high for several clocks per byte.
- `out_ready`  in  1  downstream accepts `out_data` this cycle.
- `out_data`  out  8  payload byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_last`  out  1  marks the final payload byte of the frame; qualified by `out_valid`.
- `frame_ok`  out  1  one-cycle pulse: checksum matched, drain begins.
- `frame_err`  out  1  one-cycle pulse: frame or byte dropped.
- `err_code`  out  2  0 overrun, 1 bad length, 2 checksum, 3 timeout; meaningful only while `frame_err` is high, 0 otherwise.
- `busy`  out  1  high in any state other than HUNT.

## Operation
- **Byte event.**
  - A byte event is `rx_data_ready & ~rdy_q`, where `rdy_q` is `rx_data_ready` registered.
  - `rdy_q` resets to 1, so a flag already high when reset releases is ignored.
  - Exactly one event is produced per receiver byte, regardless of how long the flag stays high.
- **States** (encoded: HUNT, LEN, PAYLOAD, CHECK, DRAIN).
  - **HUNT**
    - Event with `rx_data == sof_byte` goes to LEN.
    - Any other byte is discarded silently, with no error.
  - **LEN**
    - Event with a value of 0 or greater than `max_len`: `frame_err` with code 1, then HUNT.
    - Otherwise `len <= rx_data`, `sum <= rx_data`, `wr_idx <= 0`, then PAYLOAD.
  - **PAYLOAD**
    - Each event writes `buf[wr_idx] <= rx_data`, updates `sum <= sum + rx_data` (mod 256) and increments `wr_idx`.
    - The event that writes index `len-1` moves to CHECK.
  - **CHECK**
    - Event with `rx_data == sum`: `frame_ok` pulse, `rd_idx <= 0`, then DRAIN.
    - Otherwise `frame_err` with code 2, then HUNT. The buffer contents are abandoned.
  - **DRAIN**
    - `out_valid` = 1, `out_data` = `buf[rd_idx]`, `out_last` = (`rd_idx == len-1`).
    - A beat transfers when `out_valid && out_ready`; `rd_idx` then increments.
    - Transfer of the last beat returns to HUNT.
    - A byte event during DRAIN is dropped (including a SOF byte) and raises `frame_err` with code 0. Draining continues unaffected.
- **Timeout.**
  - `idle_cnt` runs only in LEN, PAYLOAD and CHECK.
  - It clears on every byte event and on entry to LEN.
  - When it reaches `timeout_cycles` with no event: `frame_err` with code 3, then HUNT.
  - A byte event in the same cycle takes priority; the counter clears and no timeout fires.
- **Arithmetic.**
  - `sum` is 8-bit and wraps.
  - Indices are `$clog2(max_len)` bits wide (minimum 1) and never exceed `len-1`.
- **Reset mid-operation.**
  - State goes to HUNT.
  - Every output goes low immediately (asynchronously): `out_valid`, `out_last`, `frame_ok`, `frame_err`, `err_code`, `busy`, `out_data`.
  - Any partial or draining frame is lost. Buffer contents need no reset.

## Timing
- A byte event is acted on at the first rising edge where `rx_data_ready` is sampled high. State, `frame_ok` and `frame_err` are registered and appear the following cycle.
- CHECK byte sampled at edge N: at edge N+1, `frame_ok` = 1, `out_valid` = 1 and the first byte is on `out_data`.
  - Minimum frame latency (checksum byte to first payload byte) is 1 clock.
- Holding `out_ready` = 1 drains one byte per clock. Drain of `len` bytes takes `len` clocks.
- After the last transfer, `out_valid` drops at the next edge. HUNT accepts an event in that same cycle.
- Once asserted, `out_valid` stays high until a transfer occurs; `out_data` and `out_last` are stable while stalled.
- `frame_ok` and `frame_err` are never high in the same cycle.

## Test plan
- **Good frame, no stall.** Bytes A5 03 01 02 03 09 → one `frame_ok` pulse, then `out_data` 01, 02, 03 on consecutive clocks with `out_ready` = 1. `out_last` is high only on 03. `busy` is low after the drain.
- **Checksum error.** A5 03 01 02 03 0A → `frame_err` with code 2 and no `out_valid`. A following good frame A5 01 7F 80 then produces a single byte 7F with `out_last`.
- **Length errors and noise.** Leading noise 00 FF 11, then A5 00 → code 1. Then A5 11 with `max_len` = 16 → code 1. Noise alone never asserts `frame_err`.
- **Timeout.** A5 02 55, then silence → `frame_err` with code 3 exactly `timeout_cycles` clocks after the 55 event. An event injected in the cycle the count would expire suppresses the timeout.
- **Backpressure and overrun.** Good frame A5 02 AA BB 67 with `out_ready` = 0 for 200 clocks while byte 33 arrives → `frame_err` with code 0. `out_data` is held at AA throughout. Releasing `out_ready` then drains AA, BB.
- **Reset mid-drain and held flag.** Assert `reset` during DRAIN → all outputs 0 asynchronously. Release `reset` with `rx_data_ready` held high → no byte event until the flag goes low and rises again.
